dispsync_scan: RTL
==================

Name: dispsync_scan

Overview:
Parametrised, self-timed successor to the 4-digit hex display multiplexer. It time-multiplexes DIGITS hex nibbles onto one shared 4-bit hex bus and an active-low anode vector, using its own prescaler and digit counter, so no external Scan input is needed. It adds double-buffered frame-aligned loading, per-digit blanking, a decimal point per digit, leading-zero suppression and a frame tick. It sits between the score/game logic and the seven-segment decoder on the board.

Parameters:
DIGITS, 4, number of multiplexed digits; legal range 2..8.
SCAN_DIV, 50000, clk cycles each digit stays lit; legal minimum is 1.
SCAN_W, clog2(DIGITS), width of the scan index; derived, not overridden.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
en  in  1  scan enable; 0 freezes the counters and darkens the display.
hexs  in  4*DIGITS  digit nibbles; digit i is hexs[4i+3:4i]; digit DIGITS-1 is the most significant.
dp  in  DIGITS  per-digit decimal point; 1 = lit.
blank_mask  in  DIGITS  per-digit blank; 1 = digit dark.
lz_en  in  1  leading-zero suppression enable.
load  in  1  single-cycle request to update the displayed contents.
hex  out  4  nibble for the active digit.
an  out  DIGITS  anode select, active-low, one-hot-low.
dp_n  out  1  decimal point, active-low.
scan  out  SCAN_W  current digit index.
frame_tick  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (async, rst_n=0) forces: pre=0, scan=0, shadow regs (hexs/dp/blank/lz) = 0, pend=1, an = all ones, hex=0, dp_n=1, frame_tick=0.
- Prescaler: while en=1, pre counts 0..SCAN_DIV-1. "Step" means pre==SCAN_DIV-1 and en=1; on a step, pre goes to 0 and scan advances by 1.
- Scan wrap: when scan==DIGITS-1 and a step occurs, scan goes to 0. That edge is the frame boundary. With SCAN_DIV=1, a step occurs every cycle.
- Load: load=1 sets the sticky flag pend.
  - At a frame boundary where pend=1 or load=1, the shadow regs capture hexs, dp, blank_mask and lz_en, and pend clears.
  - A load on the boundary cycle itself is captured in the same edge.
  - Inputs change freely mid-frame and are never visible before the next boundary.
- frame_tick is a registered pulse: 1 for exactly the cycle after a frame boundary edge, 0 otherwise.
- Digit visibility: digit i is visible when en=1, blank_sh[i]=0, and it is not suppressed.
  - Suppressed means lz_sh=1, i>0, and all shadow nibbles j in i..DIGITS-1 are 0.
  - Digit 0 is never suppressed.
- Outputs are registered and lag the scan register by one cycle. Each edge loads:
  - an: bit[scan]=0 if the digit is visible, all other bits 1.
  - hex: nibble[scan] if visible, else 0.
  - dp_n: ~dp_sh[scan] if visible, else 1.
- an never has more than one zero bit; no output decodes combinationally from a multi-bit counter.
- en=0: pre and scan hold; the next edge drives an = all ones, hex=0, dp_n=1; no frame_tick.
  - load is still recorded in pend.
  - On re-enable, counting resumes from the held pre/scan values.
- Reset mid-frame discards pend contents and the shadow regs; the display shows 0s until the first boundary after reset, which loads the inputs because pend=1.

Test Plan:
1. DIGITS=4, SCAN_DIV=4, hexs=16'hC639, en=1 after reset. Frame 1 shows 0 on all digits. From cycle 17, an steps 1110, 1101, 1011, 0111 (4 cycles each) with hex 9, 3, 6, C.
2. Mid-frame, at scan=2, set hexs=16'h1234 and pulse load. The current frame still shows 6 then C. The next frame shows 4, 3, 2, 1. frame_tick pulses exactly every 16 cycles.
3. lz_en=1, hexs=16'h0050 (loaded). Slots 3 and 2 show an=1111. Slot 1 shows hex=5, slot 0 shows hex=0. With hexs=16'h0000, only slot 0 lights, with hex=0.
4. blank_mask=4'b0100, dp=4'b0001. Slot 2 shows an=1111 and dp_n=1. dp_n=0 only during slot 0.
5. Drop en at scan=1 after 2 cycles of the slot. The next edge gives an=1111, scan holds 1, and no frame_tick. Raise en: slot 1 relights for its 2 remaining cycles, then moves to slot 2.
6. Assert rst_n=0 between clock edges during slot 3. an=1111, scan=0 and frame_tick=0 immediately, with no clock edge. After release, the first-frame-zeros behaviour of scenario 1 repeats.

Source files
------------

// File: rtl/dispsync_scan_if.sv
// Bundles the display-scan control inputs and the multiplexed display outputs.
// The game logic drives the master side and the scanner drives the slave side.
interface dispsync_scan_if #(
    parameter int DIGITS = 4
);
    localparam int SCAN_W = $clog2(DIGITS);

    logic                  en;
    logic [4*DIGITS-1:0]   hexs;
    logic [DIGITS-1:0]     dp;
    logic [DIGITS-1:0]     blank_mask;
    logic                  lz_en;
    logic                  load;

    logic [3:0]            hex;
    logic [DIGITS-1:0]     an;
    logic                  dp_n;
    logic [SCAN_W-1:0]     scan;
    logic                  frame_tick;

    modport master (
        output en, hexs, dp, blank_mask, lz_en, load,
        input  hex, an, dp_n, scan, frame_tick
    );

    modport slave (
        input  en, hexs, dp, blank_mask, lz_en, load,
        output hex, an, dp_n, scan, frame_tick
    );
endinterface

// File: rtl/dispsync_scan.sv
// Self-timed multiplexer for DIGITS hex digits with frame-aligned double buffering,
// per-digit blanking, decimal points, leading-zero suppression and a frame tick.
module dispsync_scan #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    dispsync_scan_if.slave   io_bus
);
    localparam int SCAN_W = $clog2(DIGITS);
    localparam int PRE_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(SCAN_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(DIGITS - 1);

    logic [PRE_W-1:0]      r_pre;
    logic [SCAN_W-1:0]     r_scan;
    logic                  r_pend;
    logic [4*DIGITS-1:0]   r_hexSh;
    logic [DIGITS-1:0]     r_dpSh;
    logic [DIGITS-1:0]     r_blankSh;
    logic                  r_lzSh;
    logic                  r_tick;
    logic [DIGITS-1:0]     r_an;
    logic [3:0]            r_hex;
    logic                  r_dpN;

    logic                  w_step;
    logic                  w_boundary;
    logic [DIGITS-1:0]     w_zeroFrom;
    logic [3:0]            w_nib;
    logic                  w_dpSel;
    logic                  w_blankSel;
    logic                  w_zeroSel;
    logic                  w_vis;
    logic [DIGITS-1:0]     w_anNext;

    assign w_step     = io_bus.en && (r_pre == PRE_MAX);
    assign w_boundary = w_step && (r_scan == SCAN_MAX);

    // w_zeroFrom[i] is set when every shadow nibble from digit i upward is zero.
    always_comb begin
        w_zeroFrom = '0;
        w_zeroFrom[DIGITS-1] = (r_hexSh[4*DIGITS-1 -: 4] == 4'h0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            w_zeroFrom[i] = w_zeroFrom[i+1] && (r_hexSh[4*i +: 4] == 4'h0);
        end
    end

    always_comb begin
        w_nib      = 4'h0;
        w_dpSel    = 1'b0;
        w_blankSel = 1'b0;
        w_zeroSel  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_scan == SCAN_W'(i)) begin
                w_nib      = r_hexSh[4*i +: 4];
                w_dpSel    = r_dpSh[i];
                w_blankSel = r_blankSh[i];
                w_zeroSel  = w_zeroFrom[i];
            end
        end
    end

    // Digit 0 is exempt from suppression so an all-zero value still shows one 0.
    assign w_vis = io_bus.en && !w_blankSel &&
                   !(r_lzSh && (r_scan != '0) && w_zeroSel);

    always_comb begin
        w_anNext = '1;
        for (int i = 0; i < DIGITS; i++) begin
            w_anNext[i] = !(w_vis && (r_scan == SCAN_W'(i)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre  <= '0;
            r_scan <= '0;
        end else if (w_step) begin
            r_pre  <= '0;
            r_scan <= (r_scan == SCAN_MAX) ? '0 : r_scan + SCAN_W'(1);
        end else if (io_bus.en) begin
            r_pre  <= r_pre + PRE_W'(1);
        end
    end

    // A load arriving on the boundary cycle itself is captured by that same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend    <= 1'b1;
            r_hexSh   <= '0;
            r_dpSh    <= '0;
            r_blankSh <= '0;
            r_lzSh    <= 1'b0;
        end else if (w_boundary) begin
            r_pend <= 1'b0;
            if (r_pend || io_bus.load) begin
                r_hexSh   <= io_bus.hexs;
                r_dpSh    <= io_bus.dp;
                r_blankSh <= io_bus.blank_mask;
                r_lzSh    <= io_bus.lz_en;
            end
        end else if (io_bus.load) begin
            r_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an   <= '1;
            r_hex  <= 4'h0;
            r_dpN  <= 1'b1;
            r_tick <= 1'b0;
        end else begin
            r_an   <= w_anNext;
            r_hex  <= w_vis ? w_nib : 4'h0;
            r_dpN  <= w_vis ? !w_dpSel : 1'b1;
            r_tick <= w_boundary;
        end
    end

    assign io_bus.an         = r_an;
    assign io_bus.hex        = r_hex;
    assign io_bus.dp_n       = r_dpN;
    assign io_bus.scan       = r_scan;
    assign io_bus.frame_tick = r_tick;
endmodule
